// File: rtl/nanov_regfile_pkg.sv
// Shared constants and elaboration helpers for the nanoV digit-serial register file.
package nanov_regfile_pkg;

   localparam int unsigned XLEN_DEF    = 32;
   localparam int unsigned NREGS_RV32E = 16;
   localparam int unsigned NREGS_RV32I = 32;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   // DIGIT must be a power of two no wider than a byte and must tile XLEN exactly.
   function automatic bit digit_legal(input int unsigned digit, input int unsigned xlen);
      if (!(digit == 1 || digit == 2 || digit == 4 || digit == 8)) return 1'b0;
      return (xlen >= digit) && ((xlen % digit) == 0);
   endfunction

endpackage

// File: rtl/nanov_serial_word.sv
// One XLEN-bit register rotating right by DIGIT bits per unstalled clock, LSB digit first.
module nanov_serial_word #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DIGIT       = 1,
   parameter bit          RESET_CLEAR = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             wr_sel,
   input  logic [DIGIT-1:0] wr_data,
   output logic [DIGIT-1:0] cur_digit
);

   logic [XLEN-1:0]  word_q;
   logic [XLEN-1:0]  word_d;
   logic [DIGIT-1:0] inject;

   // The outgoing digit re-enters at the MSB end unless a write replaces it.
   assign inject = wr_sel ? wr_data : word_q[DIGIT-1:0];

   if (XLEN > DIGIT) begin : g_rot
      assign word_d = {inject, word_q[XLEN-1:DIGIT]};
   end else begin : g_single
      assign word_d = inject;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if (RESET_CLEAR) word_q <= '0;
      end else if (!stall) begin
         word_q <= word_d;
      end
   end

   assign cur_digit = word_q[DIGIT-1:0];

endmodule

// File: rtl/nanov_serial_regfile.sv
// Digit-serial register file: x0 reads zero, two read ports, one write port, forwarding, stall.
module nanov_serial_regfile
   import nanov_regfile_pkg::*;
#(
   parameter int unsigned  XLEN        = XLEN_DEF,
   parameter int unsigned  NREGS       = NREGS_RV32E,
   parameter int unsigned  DIGIT       = 1,
   parameter bit           RESET_CLEAR = 1'b1,
   localparam int unsigned AW          = clog2(NREGS),
   localparam int unsigned NDIG        = XLEN / DIGIT,
   localparam int unsigned PW          = (clog2(NDIG) > 1) ? clog2(NDIG) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   input  logic [AW-1:0]    rd_addr,
   input  logic             wr_en,
   input  logic [DIGIT-1:0] wr_data,
   input  logic             fwd_en,
   output logic [DIGIT-1:0] rs1_data,
   output logic [DIGIT-1:0] rs2_data,
   output logic [PW-1:0]    digit_pos,
   output logic             word_start
);

   logic [PW-1:0]    pos_q;
   logic [DIGIT-1:0] cur [1:NREGS-1];
   logic [DIGIT-1:0] rs1_mem;
   logic [DIGIT-1:0] rs2_mem;
   logic             fwd1;
   logic             fwd2;

   if (!digit_legal(DIGIT, XLEN)) begin : g_bad_digit
      $fatal(1, "nanov_serial_regfile: DIGIT must be 1, 2, 4 or 8 and divide XLEN");
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q <= '0;
      end else if (!stall) begin
         pos_q <= (pos_q == PW'(NDIG - 1)) ? '0 : pos_q + 1'b1;
      end
   end

   // x0 has no storage; indices at or above NREGS never match a word.
   for (genvar i = 1; i < NREGS; i++) begin : g_word
      nanov_serial_word #(
         .XLEN        (XLEN),
         .DIGIT       (DIGIT),
         .RESET_CLEAR (RESET_CLEAR)
      ) u_word (
         .clk       (clk),
         .rst       (rst),
         .stall     (stall),
         .wr_sel    (wr_en && !stall && (rd_addr == AW'(i))),
         .wr_data   (wr_data),
         .cur_digit (cur[i])
      );
   end

   always_comb begin
      rs1_mem = '0;
      rs2_mem = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         if (rs1_addr == AW'(i)) rs1_mem = cur[i];
         if (rs2_addr == AW'(i)) rs2_mem = cur[i];
      end
   end

   always_comb begin
      fwd1       = fwd_en && wr_en && (rd_addr != '0) && (rs1_addr == rd_addr);
      fwd2       = fwd_en && wr_en && (rd_addr != '0) && (rs2_addr == rd_addr);
      rs1_data   = fwd1 ? wr_data : rs1_mem;
      rs2_data   = fwd2 ? wr_data : rs2_mem;
      digit_pos  = pos_q;
      word_start = (pos_q == '0);
   end

endmodule

// File: tb/tb_nanov_serial_regfile.sv
// Bench for nanov_serial_regfile: three instances (DIGIT=4/16 regs, DIGIT=1/32 regs, DIGIT=4/12 regs no clear).
module tb_nanov_serial_regfile;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [3:0] sb_q[$];
   logic       sb_b[$];

   // Instance A: XLEN 32, DIGIT 4, NREGS 16, RESET_CLEAR 1
   logic       a_stall, a_wr_en, a_fwd_en;
   logic [3:0] a_rs1_addr, a_rs2_addr, a_rd_addr;
   logic [3:0] a_wr_data, a_rs1_data, a_rs2_data;
   logic [2:0] a_digit_pos;
   logic       a_word_start;

   // Instance B: XLEN 32, DIGIT 1, NREGS 32, RESET_CLEAR 1
   logic       b_stall, b_wr_en, b_fwd_en;
   logic [4:0] b_rs1_addr, b_rs2_addr, b_rd_addr;
   logic       b_wr_data, b_rs1_data, b_rs2_data;
   logic [4:0] b_digit_pos;
   logic       b_word_start;

   // Instance C: XLEN 32, DIGIT 4, NREGS 12, RESET_CLEAR 0
   logic       c_stall, c_wr_en, c_fwd_en;
   logic [3:0] c_rs1_addr, c_rs2_addr, c_rd_addr;
   logic [3:0] c_wr_data, c_rs1_data, c_rs2_data;
   logic [2:0] c_digit_pos;
   logic       c_word_start;

   nanov_serial_regfile #(.XLEN(32), .NREGS(16), .DIGIT(4), .RESET_CLEAR(1'b1)) u_dut_a (
      .clk(clk), .rst(rst), .stall(a_stall), .rs1_addr(a_rs1_addr), .rs2_addr(a_rs2_addr),
      .rd_addr(a_rd_addr), .wr_en(a_wr_en), .wr_data(a_wr_data), .fwd_en(a_fwd_en),
      .rs1_data(a_rs1_data), .rs2_data(a_rs2_data), .digit_pos(a_digit_pos),
      .word_start(a_word_start)
   );

   nanov_serial_regfile #(.XLEN(32), .NREGS(32), .DIGIT(1), .RESET_CLEAR(1'b1)) u_dut_b (
      .clk(clk), .rst(rst), .stall(b_stall), .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
      .rd_addr(b_rd_addr), .wr_en(b_wr_en), .wr_data(b_wr_data), .fwd_en(b_fwd_en),
      .rs1_data(b_rs1_data), .rs2_data(b_rs2_data), .digit_pos(b_digit_pos),
      .word_start(b_word_start)
   );

   nanov_serial_regfile #(.XLEN(32), .NREGS(12), .DIGIT(4), .RESET_CLEAR(1'b0)) u_dut_c (
      .clk(clk), .rst(rst), .stall(c_stall), .rs1_addr(c_rs1_addr), .rs2_addr(c_rs2_addr),
      .rd_addr(c_rd_addr), .wr_en(c_wr_en), .wr_data(c_wr_data), .fwd_en(c_fwd_en),
      .rs1_data(c_rs1_data), .rs2_data(c_rs2_data), .digit_pos(c_digit_pos),
      .word_start(c_word_start)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_rs1_addr = 4'd5;
      a_rs2_addr = 4'd7;
      b_rs1_addr = 5'd31;
      #1;
      checks++;
      if (a_digit_pos !== 3'd0) begin
         errors++; $display("FAIL reset_pos got %0d want 0", a_digit_pos);
      end
      checks++;
      if (a_word_start !== 1'b1) begin
         errors++; $display("FAIL reset_word_start got %b want 1", a_word_start);
      end
      checks++;
      if (a_rs1_data !== 4'h0 || a_rs2_data !== 4'h0) begin
         errors++; $display("FAIL reset_data got %h/%h want 0/0", a_rs1_data, a_rs2_data);
      end
      checks++;
      if (b_rs1_data !== 1'b0 || b_word_start !== 1'b1) begin
         errors++; $display("FAIL reset_b got data %b ws %b want 0 1", b_rs1_data, b_word_start);
      end
      checks++;
      if (c_digit_pos !== 3'd0 || c_word_start !== 1'b1) begin
         errors++; $display("FAIL reset_c got pos %0d ws %b want 0 1", c_digit_pos, c_word_start);
      end
   endtask

   task automatic test_write_read();
      logic [31:0] val;
      logic [3:0]  exp;
      val = 32'h12345678;
      for (int i = 0; i < 8; i++) begin
         a_wr_en   = 1'b1;
         a_rd_addr = 4'd5;
         a_wr_data = val[4*i +: 4];
         sb_q.push_back(val[4*i +: 4]);
         tick();
      end
      a_wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a_rs1_addr = 4'd5;
         #1;
         exp = sb_q.pop_front();
         checks++;
         if (a_rs1_data !== exp) begin
            errors++; $display("FAIL wr_read d%0d got %h want %h", i, a_rs1_data, exp);
         end
         checks++;
         if (a_digit_pos !== 3'(i) || a_word_start !== (i == 0)) begin
            errors++;
            $display("FAIL wr_read_pos d%0d got pos %0d ws %b", i, a_digit_pos, a_word_start);
         end
         tick();
      end
   endtask

   task automatic test_forward();
      logic [31:0] model;
      logic [31:0] x5;
      logic [3:0]  exp;
      model = 32'h76543210;
      x5    = 32'h12345678;
      // Fill x7 with fwd_en low: reads must show the old (zero) contents.
      for (int i = 0; i < 8; i++) begin
         a_wr_en = 1'b1; a_rd_addr = 4'd7; a_wr_data = model[4*i +: 4];
         a_fwd_en = 1'b0; a_rs1_addr = 4'd7;
         sb_q.push_back(4'h0);
         #1;
         exp = sb_q.pop_front();
         checks++;
         if (a_rs1_data !== exp) begin
            errors++; $display("FAIL nofwd_old d%0d got %h want %h", i, a_rs1_data, exp);
         end
         tick();
      end
      a_wr_en = 1'b1; a_fwd_en = 1'b1; a_wr_data = 4'hA;
      a_rs1_addr = 4'd7; a_rs2_addr = 4'd7;
      #1;
      checks++;
      if (a_rs1_data !== 4'hA || a_rs2_data !== 4'hA) begin
         errors++; $display("FAIL fwd_both got %h/%h want a/a", a_rs1_data, a_rs2_data);
      end
      model[3:0] = 4'hA;
      tick();
      a_rs2_addr = 4'd5;
      #1;
      checks++;
      if (a_rs1_data !== 4'hA || a_rs2_data !== x5[7:4]) begin
         errors++;
         $display("FAIL fwd_indep got %h/%h want a/%h", a_rs1_data, a_rs2_data, x5[7:4]);
      end
      model[7:4] = 4'hA;
      tick();
      a_fwd_en = 1'b0;
      #1;
      checks++;
      if (a_rs1_data !== model[11:8]) begin
         errors++; $display("FAIL fwd_off got %h want %h", a_rs1_data, model[11:8]);
      end
      model[11:8] = 4'hA;
      tick();
      a_wr_en = 1'b0;
      for (int i = 3; i < 8; i++) tick();
      for (int i = 0; i < 8; i++) sb_q.push_back(model[4*i +: 4]);
      for (int i = 0; i < 8; i++) begin
         a_rs1_addr = 4'd7;
         #1;
         exp = sb_q.pop_front();
         checks++;
         if (a_rs1_data !== exp) begin
            errors++; $display("FAIL fwd_stored d%0d got %h want %h", i, a_rs1_data, exp);
         end
         tick();
      end
   endtask

   task automatic test_x0_range();
      logic [31:0] x5;
      x5 = 32'h12345678;
      for (int i = 0; i < 8; i++) begin
         a_wr_en = 1'b1; a_rd_addr = 4'd0; a_wr_data = 4'hF; a_fwd_en = 1'b1;
         a_rs1_addr = 4'd0; a_rs2_addr = 4'd0;
         c_wr_en = 1'b1; c_rd_addr = 4'd14; c_wr_data = 4'hF; c_fwd_en = 1'b0;
         c_rs1_addr = 4'd14;
         #1;
         checks++;
         if (a_rs1_data !== 4'h0 || a_rs2_data !== 4'h0 || c_rs1_data !== 4'h0) begin
            errors++;
            $display("FAIL x0_wr d%0d got %h/%h/%h want 0", i, a_rs1_data, a_rs2_data, c_rs1_data);
         end
         tick();
      end
      a_wr_en = 1'b0; a_fwd_en = 1'b0; c_wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a_rs1_addr = 4'd0; a_rs2_addr = 4'd5; c_rs1_addr = 4'd14;
         #1;
         checks++;
         if (a_rs1_data !== 4'h0 || c_rs1_data !== 4'h0 || a_rs2_data !== x5[4*i +: 4]) begin
            errors++;
            $display("FAIL x0_rd d%0d got %h/%h/%h want 0/0/%h",
                     i, a_rs1_data, c_rs1_data, a_rs2_data, x5[4*i +: 4]);
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [31:0] val;
      val = 32'h12345678;
      a_rs1_addr = 4'd5; a_fwd_en = 1'b0;
      for (int p = 0; p < 3; p++) begin
         #1;
         checks++;
         if (a_rs1_data !== val[4*p +: 4] || a_digit_pos !== 3'(p)) begin
            errors++;
            $display("FAIL stall_pre d%0d got %h pos %0d want %h", p, a_rs1_data, a_digit_pos,
                     val[4*p +: 4]);
         end
         tick();
      end
      for (int s = 0; s < 3; s++) begin
         a_stall = 1'b1; a_wr_en = 1'b1; a_rd_addr = 4'd5; a_wr_data = 4'hF;
         #1;
         checks++;
         if (a_digit_pos !== 3'd3 || a_rs1_data !== val[15:12] || a_word_start !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold s%0d got pos %0d data %h want 3 %h",
                     s, a_digit_pos, a_rs1_data, val[15:12]);
         end
         tick();
      end
      a_stall = 1'b0; a_wr_en = 1'b0;
      for (int n = 0; n < 13; n++) begin
         #1;
         checks++;
         if (a_rs1_data !== val[4*((n+3)%8) +: 4] || a_digit_pos !== 3'((n + 3) % 8)) begin
            errors++;
            $display("FAIL stall_post n%0d got %h pos %0d want %h", n, a_rs1_data, a_digit_pos,
                     val[4*((n+3)%8) +: 4]);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] dead;
      logic [3:0]  exp;
      dead = 32'hDEADBEEF;
      checks++;
      if (a_word_start !== 1'b1) begin
         errors++; $display("FAIL rmid_start got ws %b want 1", a_word_start);
      end
      for (int i = 0; i < 8; i++) begin
         a_wr_en = 1'b1; a_rd_addr = 4'd3; a_wr_data = dead[4*i +: 4];
         c_wr_en = 1'b1; c_rd_addr = 4'd3; c_wr_data = dead[4*i +: 4];
         sb_q.push_back(dead[4*i +: 4]);
         tick();
      end
      a_wr_en = 1'b0; c_wr_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_rs1_addr = 4'd3;
         #1;
         exp = sb_q.pop_front();
         checks++;
         if (a_rs1_data !== exp) begin
            errors++; $display("FAIL rmid_pre d%0d got %h want %h", i, a_rs1_data, exp);
         end
         tick();
      end
      sb_q.delete();
      checks++;
      if (a_digit_pos !== 3'd5) begin
         errors++; $display("FAIL rmid_pos5 got %0d want 5", a_digit_pos);
      end
      // Stall alongside reset: reset must still take effect.
      rst = 1'b1; a_stall = 1'b1;
      tick();
      rst = 1'b0; a_stall = 1'b0;
      for (int p = 0; p < 8; p++) begin
         a_rs1_addr = 4'd3; c_rs1_addr = 4'd3;
         #1;
         checks++;
         if (a_digit_pos !== 3'(p) || a_word_start !== (p == 0)) begin
            errors++;
            $display("FAIL rmid_pos p%0d got %0d ws %b", p, a_digit_pos, a_word_start);
         end
         checks++;
         if (a_rs1_data !== 4'h0) begin
            errors++; $display("FAIL rmid_clear p%0d got %h want 0", p, a_rs1_data);
         end
         checks++;
         if (c_rs1_data !== dead[4*((p+5)%8) +: 4]) begin
            errors++;
            $display("FAIL rmid_keep p%0d got %h want %h", p, c_rs1_data, dead[4*((p+5)%8) +: 4]);
         end
         tick();
      end
   endtask

   task automatic test_digit1();
      logic [31:0] val;
      logic        exp;
      int          n;
      val = 32'h80000001;
      n   = 0;
      while (b_word_start !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (b_word_start !== 1'b1) begin
         errors++; $display("FAIL d1_wait got ws %b want 1 within 40 cycles", b_word_start);
      end
      for (int i = 0; i < 32; i++) begin
         b_wr_en = 1'b1; b_rd_addr = 5'd31; b_wr_data = val[i];
         sb_b.push_back(val[i]);
         tick();
      end
      b_wr_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         b_rs1_addr = 5'd31; b_rs2_addr = 5'd30;
         #1;
         exp = sb_b.pop_front();
         checks++;
         if (b_rs1_data !== exp || b_rs2_data !== 1'b0 || b_digit_pos !== 5'(i)) begin
            errors++;
            $display("FAIL d1_read b%0d got %b/%b pos %0d want %b/0", i, b_rs1_data, b_rs2_data,
                     b_digit_pos, exp);
         end
         tick();
      end
      checks++;
      if (b_digit_pos !== 5'd0 || b_word_start !== 1'b1) begin
         errors++; $display("FAIL d1_wrap got pos %0d ws %b want 0 1", b_digit_pos, b_word_start);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_stall = 0; a_wr_en = 0; a_fwd_en = 0; a_rs1_addr = 0; a_rs2_addr = 0; a_rd_addr = 0;
      a_wr_data = 0;
      b_stall = 0; b_wr_en = 0; b_fwd_en = 0; b_rs1_addr = 0; b_rs2_addr = 0; b_rd_addr = 0;
      b_wr_data = 0;
      c_stall = 0; c_wr_en = 0; c_fwd_en = 0; c_rs1_addr = 0; c_rs2_addr = 0; c_rd_addr = 0;
      c_wr_data = 0;
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      test_write_read();
      test_forward();
      test_x0_range();
      test_stall();
      test_reset_mid();
      test_digit1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
